// File: rtl/sim_watchdog_pkg.sv
// Shared types and defaults for the simulation watchdog.
package sim_watchdog_pkg;

  localparam int WD_CNT_W_DEF    = 32;
  localparam int WD_PRESCALE_DEF = 1000;
  localparam int WD_PROGRESS_DEF = 1000;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_EXPIRED = 2'd2,
    WD_EARLY   = 2'd3
  } wd_state_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int wd_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_watchdog_prescaler.sv
// Divides clk into counting units: unit_stb_o is high on the last cycle of each unit.
module wd_prescaler
  import sim_watchdog_pkg::*;
#(
  parameter int PRESCALE = WD_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic unit_stb_o
);

  localparam int              PW   = wd_cnt_w(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign unit_stb_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = unit_stb_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sim_watchdog.sv
// Kickable watchdog with periodic progress tick and sticky expiry flag.
// Define SIM_WATCHDOG_WINDOW_EN for window mode (kicks in the first half of the window are faults).
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int CNT_W          = WD_CNT_W_DEF,
  parameter int PRESCALE       = WD_PRESCALE_DEF,
  parameter int PROGRESS_UNITS = WD_PROGRESS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_i,
  input  logic             disarm_i,
  input  logic             kick_i,
  input  logic [CNT_W-1:0] timeout_units_i,
  output logic             tick_o,
  output logic             expired_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] units_o
);

  localparam int            GW        = wd_cnt_w(PROGRESS_UNITS);
  localparam logic [GW-1:0] PROG_LAST = GW'(PROGRESS_UNITS - 1);

  wd_state_t        state_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] units_q;
  logic [GW-1:0]    prog_q;
  logic             tick_q;
  logic             expired_q;

  logic unit_stb;
  logic presc_en;
  logic presc_clr;
  logic kick_early;
  logic prog_wrap;

`ifdef SIM_WATCHDOG_WINDOW_EN
  assign kick_early = units_q < (limit_q >> 1);
`else
  assign kick_early = 1'b0;
`endif

  assign presc_en  = (state_q == WD_ARMED);
  assign presc_clr = disarm_i
                   | (arm_i && (state_q == WD_IDLE || state_q == WD_ARMED))
                   | (kick_i && state_q == WD_ARMED && !kick_early);
  assign prog_wrap = (prog_q == PROG_LAST);

  wd_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (presc_en),
    .clr_i      (presc_clr),
    .unit_stb_o (unit_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WD_IDLE;
      limit_q   <= '0;
      units_q   <= '0;
      prog_q    <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        WD_IDLE: begin
          if (arm_i && !disarm_i) begin
            state_q <= WD_ARMED;
            limit_q <= timeout_units_i;
            units_q <= '0;
            prog_q  <= '0;
          end
        end
        WD_ARMED: begin
          if (disarm_i) begin
            state_q <= WD_IDLE;
            prog_q  <= '0;
          end else if (arm_i) begin
            limit_q <= timeout_units_i;
            units_q <= '0;
            prog_q  <= '0;
          end else if (kick_i && kick_early) begin
            state_q   <= WD_EARLY;
            expired_q <= 1'b1;
          end else begin
            // Progress measures total armed time, so kicks do not disturb it.
            if (unit_stb) begin
              prog_q <= prog_wrap ? '0 : prog_q + 1'b1;
              tick_q <= prog_wrap;
            end
            if (kick_i) begin
              units_q <= '0;
            end else if (limit_q == '0) begin
              state_q <= WD_EXPIRED;
            end else if (unit_stb) begin
              if (units_q != '1) units_q <= units_q + 1'b1;
              if (units_q == limit_q - 1'b1) state_q <= WD_EXPIRED;
            end
          end
        end
        WD_EXPIRED, WD_EARLY: begin
          if (disarm_i) begin
            state_q   <= WD_IDLE;
            expired_q <= 1'b0;
            prog_q    <= '0;
          end else begin
            expired_q <= 1'b1;
          end
        end
        default: state_q <= WD_IDLE;
      endcase
    end
  end

  assign tick_o    = tick_q;
  assign expired_o = expired_q;
  assign state_o   = state_q;
  assign units_o   = units_q;

endmodule

// File: tb/tb_sim_watchdog.sv
// Directed scoreboard bench for sim_watchdog (PRESCALE=4, PROGRESS_UNITS=2).
module tb_sim_watchdog;

  localparam int S_ST = 0, S_EXP = 1, S_UNITS = 2, S_TICK = 3;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i, disarm_i, kick_i;
  logic [31:0] tmo;
  logic        tick_o, expired_o;
  logic [1:0]  state_o;
  logic [31:0] units_o;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic tick_chk_en = 1'b0;
  logic done = 1'b0;
  logic [31:0] act;

  chk_t chk_q[$];
  int   tick_q[$];

  sim_watchdog #(.CNT_W(32), .PRESCALE(4), .PROGRESS_UNITS(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arm_i           (arm_i),
    .disarm_i        (disarm_i),
    .kick_i          (kick_i),
    .timeout_units_i (tmo),
    .tick_o          (tick_o),
    .expired_o       (expired_o),
    .state_o         (state_o),
    .units_o         (units_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int c, input int s, input logic [31:0] v, input string n);
    chk_q.push_back('{c, s, v, n});
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick1();
  endtask

  task automatic pulse(input logic a, input logic d, input logic k, input logic [31:0] t);
    arm_i = a; disarm_i = d; kick_i = k; tmo = t;
    tick1();
    arm_i = 1'b0; disarm_i = 1'b0; kick_i = 1'b0;
  endtask

  // Monitor: compares queued expectations at their cycle and tracks tick pulses.
  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        case (chk_q[i].sig)
          S_ST:    act = 32'(state_o);
          S_EXP:   act = 32'(expired_o);
          S_UNITS: act = units_o;
          default: act = 32'(tick_o);
        endcase
        n_tests++;
        if (act !== chk_q[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%0h exp=%0h", chk_q[i].name, cyc, act, chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    if (tick_chk_en) begin
      if (tick_o === 1'b1) begin
        n_tests++;
        if (tick_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick cyc=%0d got=1 exp=0", cyc);
        end else if (tick_q[0] != cyc) begin
          n_fail++;
          $display("FAIL tick_time got=%0d exp=%0d", cyc, tick_q[0]);
          void'(tick_q.pop_front());
        end else begin
          void'(tick_q.pop_front());
        end
      end else if (tick_q.size() != 0 && tick_q[0] <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_tick cyc=%0d exp_at=%0d", cyc, tick_q[0]);
        void'(tick_q.pop_front());
      end
    end
    if (done) begin
      foreach (chk_q[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL unchecked %s exp_cyc=%0d", chk_q[i].name, chk_q[i].cyc);
      end
      foreach (tick_q[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL pending_tick exp_at=%0d", tick_q[i]);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int a, b, d, r;
    rst_n = 1'b0; arm_i = 1'b0; disarm_i = 1'b0; kick_i = 1'b0; tmo = '0;
    repeat (3) tick1();
    rst_n = 1'b1;
    tick1();
    r = cyc;
    exp_at(r, S_ST, 0, "rst_state");
    exp_at(r, S_EXP, 0, "rst_expired");
    exp_at(r, S_UNITS, 0, "rst_units");
    exp_at(r, S_TICK, 0, "rst_tick");

    // Unkicked expiry, limit 3: 12 clocks to EXPIRED, flag one cycle later.
    pulse(1, 0, 0, 3); a = cyc;
    exp_at(a, S_ST, 1, "exp_armed");
    exp_at(a + 3, S_UNITS, 0, "exp_u0");
    exp_at(a + 4, S_UNITS, 1, "exp_u1");
    exp_at(a + 8, S_UNITS, 2, "exp_u2");
    exp_at(a + 11, S_ST, 1, "exp_still_armed");
    exp_at(a + 12, S_ST, 2, "exp_state");
    exp_at(a + 12, S_UNITS, 3, "exp_units_final");
    exp_at(a + 12, S_EXP, 0, "exp_latency");
    exp_at(a + 13, S_EXP, 1, "exp_flag");
    wait_until(a + 14);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 3);
    exp_at(a + 16, S_ST, 2, "exp_ignore_arm_kick");
    exp_at(a + 16, S_UNITS, 3, "exp_frozen_units");
    exp_at(a + 16, S_EXP, 1, "exp_sticky");
    pulse(0, 1, 0, 0); d = cyc;
    exp_at(d, S_ST, 0, "disarm_state");
    exp_at(d, S_EXP, 0, "disarm_expired");

    // Zero limit expires on the cycle after arm.
    pulse(1, 0, 0, 0); a = cyc;
    exp_at(a, S_ST, 1, "lim0_armed");
    exp_at(a + 1, S_ST, 2, "lim0_state");
    exp_at(a + 1, S_EXP, 0, "lim0_latency");
    exp_at(a + 2, S_EXP, 1, "lim0_flag");
    wait_until(a + 2);
    pulse(0, 1, 0, 0); d = cyc;
    exp_at(d, S_ST, 0, "lim0_disarm");

    // Kick coinciding with the terminal unit strobe wins; then disarm beats arm.
    pulse(1, 0, 0, 3); a = cyc;
    exp_at(a + 12, S_ST, 1, "kick_term_state");
    exp_at(a + 12, S_UNITS, 0, "kick_term_units");
    exp_at(a + 13, S_EXP, 0, "kick_term_expired");
    exp_at(a + 13, S_ST, 1, "kick_term_state2");
    exp_at(a + 16, S_UNITS, 1, "kick_term_restart");
    wait_until(a + 11);
    pulse(0, 0, 1, 0);
    wait_until(a + 17);
    pulse(1, 1, 0, 5); b = cyc;
    exp_at(b, S_ST, 0, "disarm_arm_state");
    exp_at(b + 4, S_ST, 0, "disarm_arm_stays");
    exp_at(b + 5, S_EXP, 0, "disarm_arm_expired");
    wait_until(b + 5);

    // Periodic kicks every 8 clocks keep the window open.
    pulse(1, 0, 0, 3); a = cyc;
    for (int m = 1; m <= 100; m++) begin
      exp_at(a + m, S_UNITS, ((m % 8) >= 4) ? 32'd1 : 32'd0, "kick_loop_units");
      exp_at(a + m, S_EXP, 0, "kick_loop_expired");
    end
    exp_at(a + 100, S_ST, 1, "kick_loop_state");
    for (int k = 1; k <= 12; k++) begin
      wait_until(a + 8 * k - 1);
      pulse(0, 0, 1, 0);
    end
    wait_until(a + 100);
    pulse(0, 1, 0, 0);

    // Progress tick every 8 clocks, unaffected by unit-aligned kicks.
    pulse(1, 0, 0, 100); a = cyc;
    tick_chk_en = 1'b1;
    for (int k = 1; k <= 6; k++) tick_q.push_back(a + 8 * k);
    exp_at(a + 8, S_UNITS, 2, "prog_u2");
    exp_at(a + 12, S_UNITS, 0, "prog_kick_u0");
    exp_at(a + 16, S_UNITS, 1, "prog_u1");
    exp_at(a + 20, S_UNITS, 0, "prog_kick_u0b");
    for (int e = 12; e <= 44; e += 8) begin
      wait_until(a + e - 1);
      pulse(0, 0, 1, 0);
    end
    wait_until(a + 51);
    tick_chk_en = 1'b0;
    pulse(0, 1, 0, 0);

    // Kick in the first half of the window, then in the second half.
    pulse(1, 0, 0, 8); a = cyc;
    exp_at(a + 8, S_UNITS, 2, "win_u2");
`ifdef SIM_WATCHDOG_WINDOW_EN
    exp_at(a + 10, S_ST, 3, "win_early_state");
    exp_at(a + 10, S_EXP, 1, "win_early_flag");
    exp_at(a + 12, S_UNITS, 2, "win_early_frozen");
    exp_at(a + 14, S_ST, 3, "win_early_sticky");
`else
    exp_at(a + 10, S_ST, 1, "nowin_state");
    exp_at(a + 10, S_UNITS, 0, "nowin_units");
    exp_at(a + 10, S_EXP, 0, "nowin_expired");
`endif
    wait_until(a + 9);
    pulse(0, 0, 1, 0);
    wait_until(a + 14);
    pulse(0, 1, 0, 0); d = cyc;
    exp_at(d, S_ST, 0, "win_disarm_state");
    exp_at(d, S_EXP, 0, "win_disarm_expired");
    pulse(1, 0, 0, 8); a = cyc;
    exp_at(a + 20, S_UNITS, 5, "win_u5");
    exp_at(a + 21, S_ST, 1, "win_late_state");
    exp_at(a + 21, S_UNITS, 0, "win_late_units");
    exp_at(a + 21, S_EXP, 0, "win_late_expired");
    wait_until(a + 20);
    pulse(0, 0, 1, 0);
    pulse(0, 1, 0, 0);

    // Reset asserted mid-ARMED with units_o=5.
    pulse(1, 0, 0, 100); a = cyc;
    exp_at(a + 20, S_UNITS, 5, "prerst_units");
    wait_until(a + 21);
    rst_n = 1'b0;
    exp_at(a + 21, S_ST, 0, "midrst_state");
    exp_at(a + 21, S_UNITS, 0, "midrst_units");
    exp_at(a + 21, S_EXP, 0, "midrst_expired");
    exp_at(a + 21, S_TICK, 0, "midrst_tick");
    tick1();
    tick1();
    rst_n = 1'b1;
    r = cyc;
    tick_chk_en = 1'b1;
    exp_at(r + 10, S_ST, 0, "postrst_state");
    exp_at(r + 10, S_UNITS, 0, "postrst_units");
    wait_until(r + 20);
    tick_chk_en = 1'b0;

    wait_until(cyc + 2);
    done = 1'b1;
  end

endmodule
